// File: rtl/rom_page_loader_pkg.sv
// -----------------------------------------------------------------------------
// rom_loader_pkg
// Shared definitions for the expansion-ROM page loader:
//   - loader_state_t : download FSM states
//   - ASCII_*        : character constants used by the extension decoder
//   - hex_nibble()   : maps one ASCII hex digit to {valid, value}
// -----------------------------------------------------------------------------
package rom_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        LOAD   = 2'd2,
        FINISH = 2'd3
    } loader_state_t;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_9 = 8'h39;
    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_F = 8'h46;
    localparam logic [7:0] ASCII_Z = 8'h5A;

    // '0'..'9' are 0x30..0x39, so the low nibble is already the value.
    // 'A'..'F' are 0x41..0x46, so the low nibble plus 9 gives 10..15.
    function automatic logic [4:0] hex_nibble(input logic [7:0] c);
        if (c >= ASCII_0 && c <= ASCII_9)
            return {1'b1, c[3:0]};
        else if (c >= ASCII_A && c <= ASCII_F)
            return {1'b1, c[3:0] + 4'd9};
        else
            return 5'b0_0000;
    endfunction

endpackage

// File: rtl/rom_page_loader_presence_map.sv
// -----------------------------------------------------------------------------
// rom_presence_map
// One bit per ROM page recording whether that page holds downloaded data.
// Ports:
//   clk_sys  : system clock
//   reset    : asynchronous active-high reset, clears every bit
//   set_en   : set the bit addressed by set_idx
//   set_idx  : page to mark present
//   clear    : clear every bit (a coincident set still wins for its page)
//   rd_idx   : lookup index
//   rd_valid : registered presence bit of rd_idx (one-cycle latency)
// -----------------------------------------------------------------------------
module rom_presence_map #(
    parameter int PAGE_BITS = 8
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 set_en,
    input  logic [PAGE_BITS-1:0] set_idx,
    input  logic                 clear,
    input  logic [PAGE_BITS-1:0] rd_idx,
    output logic                 rd_valid
);
    localparam int DEPTH = 1 << PAGE_BITS;

    logic [DEPTH-1:0] r_map;
    logic [DEPTH-1:0] w_hit;
    logic             r_rd_valid;

    // One-hot decode of the page being set this cycle.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign w_hit[gi] = set_en && (set_idx == PAGE_BITS'(gi));
        end
    endgenerate

    // Clear first, then OR in the set so a simultaneous set survives.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_map      <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_map      <= (r_map & ~{DEPTH{clear}}) | w_hit;
            r_rd_valid <= r_map[rd_idx];
        end
    end

    assign rd_valid = r_rd_valid;

endmodule

// File: rtl/rom_page_loader.sv
// -----------------------------------------------------------------------------
// rom_page_loader
// Expansion-ROM download engine between the ioctl byte stream and the SDRAM
// boot-write port. The two-character file extension selects a base page
// (hex "00".."FF", "ZZ" = page 0, "Z0" = combo: page 0 then COMBO_PAGE..).
// Each 2^PAGE_ADDR_W-byte page of the file lands in its target SDRAM page;
// bytes whose page would fall outside the map are dropped and flagged.
//
// Ports:
//   clk_sys, reset          : clock, asynchronous active-high reset
//   ioctl_download/wr/addr/dout/index/file_ext : download stream
//   map_clear               : clear the presence map
//   map_page / map_valid    : presence lookup, one-cycle latency
//   boot_wr/boot_a/boot_dout: SDRAM write port, one cycle behind ioctl_wr
//   load_done               : one-cycle pulse when a download finishes
//   load_err                : sticky error for the last download
//   load_pages              : highest accepted page offset + 1
//   load_sum                : 16-bit sum of accepted bytes
//
// Build option: define ROM_PAGE_LOADER_CHECKSUM_EN to compute load_sum;
// without it load_sum is constant 0.
// -----------------------------------------------------------------------------
module rom_page_loader #(
    parameter int PAGE_BITS   = 8,
    parameter int PAGE_ADDR_W = 14,
    parameter int ADDR_W      = 23,
    parameter int COMBO_PAGE  = (1 << PAGE_BITS) - 1
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ioctl_download,
    input  logic                 ioctl_wr,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    input  logic [7:0]           ioctl_index,
    input  logic [15:0]          ioctl_file_ext,
    input  logic                 map_clear,
    input  logic [PAGE_BITS-1:0] map_page,
    output logic                 map_valid,
    output logic                 boot_wr,
    output logic [ADDR_W-1:0]    boot_a,
    output logic [7:0]           boot_dout,
    output logic                 load_done,
    output logic                 load_err,
    output logic [PAGE_BITS:0]   load_pages,
    output logic [15:0]          load_sum
);
    import rom_loader_pkg::*;

    localparam int TW = PAGE_BITS + 1;   // target page width incl. overflow bit

    loader_state_t          r_state;
    logic                   r_dl_prev;
    logic                   r_wr_prev;
    logic                   r_last_acc;
    logic [PAGE_BITS-1:0]   r_last_tgt;
    logic [PAGE_BITS-1:0]   r_base;
    logic                   r_combo;
    logic                   r_bad;
    logic                   r_boot_wr;
    logic [ADDR_W-1:0]      r_boot_a;
    logic [7:0]             r_boot_dout;
    logic                   r_load_done;
    logic                   r_load_err;
    logic [PAGE_BITS:0]     r_load_pages;

    logic [PAGE_BITS-1:0]   w_off;
    logic [TW-1:0]          w_off_ext;
    logic [TW-1:0]          w_tgt;
    logic                   w_hi_zero;
    logic                   w_in_load;
    logic                   w_accept;
    logic                   w_drop;
    logic [ADDR_W-1:0]      w_boot_a;
    logic [4:0]             w_hi_nib;
    logic [4:0]             w_lo_nib;
    logic                   w_ext_zz;
    logic                   w_ext_z0;
    logic                   w_set_en;

    // ---------------------------------------------------------------- decode
    assign w_hi_nib = hex_nibble(ioctl_file_ext[15:8]);
    assign w_lo_nib = hex_nibble(ioctl_file_ext[7:0]);
    assign w_ext_zz = (ioctl_file_ext[15:8] == ASCII_Z) && (ioctl_file_ext[7:0] == ASCII_Z);
    assign w_ext_z0 = (ioctl_file_ext[15:8] == ASCII_Z) && (ioctl_file_ext[7:0] == ASCII_0);

    // ---------------------------------------------------------- target page
    assign w_off     = ioctl_addr[PAGE_ADDR_W+PAGE_BITS-1:PAGE_ADDR_W];
    assign w_off_ext = {1'b0, w_off};

    // One bit wider than the page index so overflow is detected, not wrapped.
    always_comb begin
        w_tgt = '0;
        if (r_combo) begin
            if (w_off != '0)
                w_tgt = TW'(COMBO_PAGE) + w_off_ext - TW'(1);
        end else begin
            w_tgt = {1'b0, r_base} + w_off_ext;
        end
    end

    // File offsets beyond the whole map are never valid.
    assign w_hi_zero = (ioctl_addr >> (PAGE_BITS + PAGE_ADDR_W)) == '0;

    assign w_in_load = (r_state == LOAD);
    assign w_accept  = w_in_load && ioctl_wr && !r_bad && !w_tgt[PAGE_BITS] && w_hi_zero;
    assign w_drop    = w_in_load && ioctl_wr && !w_accept;

    // MSB selects the ROM region; zero padding sits between it and the page.
    assign w_boot_a = (ADDR_W'(1) << (ADDR_W - 1))
                    | ADDR_W'({w_tgt[PAGE_BITS-1:0], ioctl_addr[PAGE_ADDR_W-1:0]});

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            // Held high so a download still in progress when reset is
            // released is not mistaken for a new rising edge.
            r_dl_prev    <= 1'b1;
            r_wr_prev    <= 1'b0;
            r_last_acc   <= 1'b0;
            r_last_tgt   <= '0;
            r_base       <= '0;
            r_combo      <= 1'b0;
            r_bad        <= 1'b0;
            r_boot_wr    <= 1'b0;
            r_boot_a     <= '0;
            r_boot_dout  <= '0;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
            r_load_pages <= '0;
        end else begin
            r_dl_prev   <= ioctl_download;
            r_wr_prev   <= ioctl_wr;
            r_last_acc  <= w_accept;
            r_last_tgt  <= w_tgt[PAGE_BITS-1:0];
            r_boot_wr   <= w_accept;
            r_load_done <= 1'b0;
            if (w_accept) begin
                r_boot_a    <= w_boot_a;
                r_boot_dout <= ioctl_dout;
            end

            case (r_state)
                IDLE: begin
                    if (ioctl_download && !r_dl_prev && (ioctl_index != 8'd0))
                        r_state <= DECODE;
                end
                DECODE: begin
                    r_state      <= LOAD;
                    r_load_pages <= '0;
                    r_base       <= '0;
                    r_combo      <= 1'b0;
                    r_bad        <= 1'b0;
                    r_load_err   <= 1'b0;
                    if (w_hi_nib[4] && w_lo_nib[4]) begin
                        r_base <= PAGE_BITS'({w_hi_nib[3:0], w_lo_nib[3:0]});
                    end else if (w_ext_z0) begin
                        r_combo <= 1'b1;
                    end else if (!w_ext_zz) begin
                        r_bad      <= 1'b1;
                        r_load_err <= 1'b1;
                    end
                end
                LOAD: begin
                    if (w_drop)
                        r_load_err <= 1'b1;
                    if (w_accept && ((w_off_ext + TW'(1)) > r_load_pages))
                        r_load_pages <= w_off_ext + TW'(1);
                    if (!ioctl_download) begin
                        r_state     <= FINISH;
                        r_load_done <= 1'b1;
                    end
                end
                FINISH: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A page is marked present when the strobe of an accepted byte ends.
    assign w_set_en = r_wr_prev && !ioctl_wr && r_last_acc;

    rom_presence_map #(
        .PAGE_BITS (PAGE_BITS)
    ) u_map (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .set_en   (w_set_en),
        .set_idx  (r_last_tgt),
        .clear    (map_clear),
        .rd_idx   (map_page),
        .rd_valid (map_valid)
    );

`ifdef ROM_PAGE_LOADER_CHECKSUM_EN
    logic [15:0] r_sum;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            r_sum <= '0;
        else if (r_state == DECODE)
            r_sum <= '0;
        else if (w_accept)
            r_sum <= r_sum + {8'h00, ioctl_dout};
    end

    assign load_sum = r_sum;
`else
    assign load_sum = 16'h0000;
`endif

    assign boot_wr    = r_boot_wr;
    assign boot_a     = r_boot_a;
    assign boot_dout  = r_boot_dout;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;
    assign load_pages = r_load_pages;

endmodule

// File: tb/tb_rom_page_loader.sv
// -----------------------------------------------------------------------------
// tb_rom_page_loader
// Directed bench for rom_page_loader. Expected SDRAM writes are queued when a
// byte is driven and matched against boot_wr/boot_a/boot_dout as they appear.
// A bench-side presence map and checksum track what the DUT should report.
// -----------------------------------------------------------------------------
module tb_rom_page_loader;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic [15:0] ioctl_file_ext;
    logic        map_clear;
    logic [7:0]  map_page;
    logic        map_valid;
    logic        boot_wr;
    logic [22:0] boot_a;
    logic [7:0]  boot_dout;
    logic        load_done;
    logic        load_err;
    logic [8:0]  load_pages;
    logic [15:0] load_sum;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [255:0] exp_map = '0;
    logic [15:0] sum_model = 16'h0000;

    always #5 clk_sys = ~clk_sys;

    rom_page_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_index    (ioctl_index),
        .ioctl_file_ext (ioctl_file_ext),
        .map_clear      (map_clear),
        .map_page       (map_page),
        .map_valid      (map_valid),
        .boot_wr        (boot_wr),
        .boot_a         (boot_a),
        .boot_dout      (boot_dout),
        .load_done      (load_done),
        .load_err       (load_err),
        .load_pages     (load_pages),
        .load_sum       (load_sum)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [22:0] exp_addr(input int page, input int offs);
        int a;
        a = 32'h0040_0000 + page * 16384 + offs;
        return a[22:0];
    endfunction

    // Scoreboard: every boot_wr cycle must match the oldest queued write.
    always @(negedge clk_sys) begin
        if (boot_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_boot_wr", 32'(boot_wr), 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("boot_a_dout", {1'b0, boot_a, boot_dout}, e);
                $display("write: boot_a=%06h boot_dout=%02h", boot_a, boot_dout);
            end
        end
    end

    task automatic start_dl(input logic [7:0] idx, input logic [15:0] ext);
        @(posedge clk_sys); #1;
        ioctl_download = 1'b1;
        ioctl_index    = idx;
        ioctl_file_ext = ext;
        if (idx != 8'd0) sum_model = 16'h0000;
        repeat (2) @(posedge clk_sys);
        $display("download: index=%0d ext=%s", idx, ext);
    endtask

    // acc: bench expects the byte to land on 'page'; clr: pulse map_clear in
    // the same cycle that the strobe falls (i.e. the presence-set cycle).
    task automatic send_byte(input logic [24:0] a, input logic [7:0] d,
                             input bit acc, input int page, input bit clr);
        @(posedge clk_sys); #1;
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (acc) begin
            exp_q.push_back({1'b0, exp_addr(page, int'(a[13:0])), d});
            sum_model = sum_model + {8'h00, d};
        end
        @(posedge clk_sys); #1;
        ioctl_wr  = 1'b0;
        map_clear = clr;
        if (clr) exp_map = '0;
        if (acc) exp_map[page] = 1'b1;
        @(posedge clk_sys); #1;
        map_clear = 1'b0;
    endtask

    task automatic end_dl(input int exp_done, input bit exp_err, input int exp_pages);
        int n;
        logic [15:0] exp_sum;
        @(posedge clk_sys); #1;
        ioctl_download = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk_sys);
            if (load_done === 1'b1) n++;
        end
`ifdef ROM_PAGE_LOADER_CHECKSUM_EN
        exp_sum = sum_model;
`else
        exp_sum = 16'h0000;
`endif
        check("load_done_pulses", 32'(n), 32'(exp_done));
        check("load_err", 32'(load_err), 32'(exp_err));
        check("load_pages", 32'(load_pages), 32'(exp_pages));
        check("load_sum", 32'(load_sum), 32'(exp_sum));
        $display("end: done=%0d err=%0b pages=%0d sum=%04h", n, load_err, load_pages, load_sum);
    endtask

    task automatic check_map_all();
        for (int p = 0; p < 256; p++) begin
            @(posedge clk_sys); #1;
            map_page = p[7:0];
            @(posedge clk_sys);
            @(negedge clk_sys);
            check($sformatf("map_valid[%0d]", p), 32'(map_valid), 32'(exp_map[p]));
        end
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        ioctl_index    = '0;
        ioctl_file_ext = '0;
        map_clear      = 1'b0;
        map_page       = '0;

        // Reset state
        repeat (3) @(negedge clk_sys);
        check("rst_boot_wr", 32'(boot_wr), 32'd0);
        check("rst_boot_a", 32'(boot_a), 32'd0);
        check("rst_boot_dout", 32'(boot_dout), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_load_pages", 32'(load_pages), 32'd0);
        check("rst_load_sum", 32'(load_sum), 32'd0);
        check("rst_map_valid", 32'(map_valid), 32'd0);
        @(posedge clk_sys); #1;
        reset = 1'b0;

        // Index 0 (system ROM) is ignored completely
        start_dl(8'd0, "07");
        send_byte(25'h0000000, 8'h5A, 1'b0, 0, 1'b0);
        end_dl(0, 1'b0, 0);

        // "07": pages 7 and 8
        start_dl(8'd1, "07");
        send_byte(25'h0000000, 8'h11, 1'b1, 7, 1'b0);
        send_byte(25'h0000001, 8'h22, 1'b1, 7, 1'b0);
        send_byte(25'h0000002, 8'h33, 1'b1, 7, 1'b0);
        send_byte(25'h0003FFF, 8'h44, 1'b1, 7, 1'b0);
        send_byte(25'h0004000, 8'h55, 1'b1, 8, 1'b0);
        send_byte(25'h0004001, 8'h66, 1'b1, 8, 1'b0);
        send_byte(25'h0007FFF, 8'h77, 1'b1, 8, 1'b0);
        end_dl(1, 1'b0, 2);
        check_map_all();

        // "Z0": first page to 0, second to 0xFF
        start_dl(8'd2, "Z0");
        send_byte(25'h0000000, 8'hA1, 1'b1, 0, 1'b0);
        send_byte(25'h0003FFF, 8'hA2, 1'b1, 0, 1'b0);
        send_byte(25'h0004000, 8'hA3, 1'b1, 255, 1'b0);
        send_byte(25'h0007FFF, 8'hA4, 1'b1, 255, 1'b0);
        end_dl(1, 1'b0, 2);
        check_map_all();

        // "FF": second page overflows the map and is dropped
        start_dl(8'd1, "FF");
        send_byte(25'h0000000, 8'hB1, 1'b1, 255, 1'b0);
        send_byte(25'h0003FFF, 8'hB2, 1'b1, 255, 1'b0);
        send_byte(25'h0004000, 8'hB3, 1'b0, 0, 1'b0);
        send_byte(25'h0007FFF, 8'hB4, 1'b0, 0, 1'b0);
        end_dl(1, 1'b1, 1);

        // "Q3": bad extension, nothing written, map unchanged
        start_dl(8'd1, "Q3");
        send_byte(25'h0000000, 8'hC1, 1'b0, 0, 1'b0);
        send_byte(25'h0000010, 8'hC2, 1'b0, 0, 1'b0);
        end_dl(1, 1'b1, 0);
        check_map_all();

        // "ZZ": page 0; an offset beyond the whole map is dropped
        start_dl(8'd3, "ZZ");
        send_byte(25'h0000005, 8'hD1, 1'b1, 0, 1'b0);
        send_byte(25'h0400000, 8'hD2, 1'b0, 0, 1'b0);
        end_dl(1, 1'b1, 1);

        // "03": checksum bytes; map_clear coincides with the last page-3 set
        start_dl(8'd1, "03");
        send_byte(25'h0000000, 8'hFF, 1'b1, 3, 1'b0);
        send_byte(25'h0000001, 8'h01, 1'b1, 3, 1'b0);
        send_byte(25'h0000002, 8'h80, 1'b1, 3, 1'b0);
        send_byte(25'h0000003, 8'h80, 1'b1, 3, 1'b1);
        end_dl(1, 1'b0, 1);
        check_map_all();

        // Reset after 100 bytes, released while the window is still open
        start_dl(8'd1, "07");
        for (int i = 0; i < 100; i++)
            send_byte(25'(i), 8'($urandom_range(0, 255)), 1'b1, 7, 1'b0);
        @(posedge clk_sys); #1;
        reset     = 1'b1;
        exp_map   = '0;
        sum_model = 16'h0000;
        @(negedge clk_sys);
        check("midrst_boot_wr", 32'(boot_wr), 32'd0);
        check("midrst_load_pages", 32'(load_pages), 32'd0);
        send_byte(25'h0000064, 8'hE1, 1'b0, 0, 1'b0);
        send_byte(25'h0000065, 8'hE2, 1'b0, 0, 1'b0);
        @(posedge clk_sys); #1;
        reset = 1'b0;
        send_byte(25'h0000066, 8'hE3, 1'b0, 0, 1'b0);
        send_byte(25'h0000067, 8'hE4, 1'b0, 0, 1'b0);
        send_byte(25'h0004000, 8'hE5, 1'b0, 0, 1'b0);
        end_dl(0, 1'b0, 0);
        check_map_all();

        repeat (4) @(posedge clk_sys);
        check("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_page_loader.md
Name: rom_page_loader

Overview:
- Parametrised expansion-ROM download engine between the mist_io ioctl stream and the SDRAM boot-write port.
- Decodes the two-character file extension to a base page, places each 2^PAGE_ADDR_W-byte page in SDRAM and records which pages hold ROMs in a presence map.
- Adds over the current single-width mapper: configurable page count, page size and combo target; bounds checking instead of wrap-around; an error flag; completion reporting.

Parameters:
- PAGE_BITS, 8: page index width; the map holds 2^PAGE_BITS pages.
- PAGE_ADDR_W, 14: byte offset within a page (16 KB).
- ADDR_W, 23: SDRAM byte address width. Must satisfy ADDR_W >= PAGE_BITS+PAGE_ADDR_W+1.
- COMBO_PAGE, 2^PAGE_BITS-1: first target page for the second and later pages of a "Z0" combo file.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high
- ioctl_download  in  1  download window
- ioctl_wr  in  1  byte strobe
- ioctl_addr  in  25  byte offset within file
- ioctl_dout  in  8  byte data
- ioctl_index  in  8  menu index; 0 = system ROM, ignored by this block
- ioctl_file_ext  in  16  last two extension characters, ASCII, [15:8] first
- map_clear  in  1  clear the whole presence map
- map_page  in  PAGE_BITS  presence lookup index
- map_valid  out  1  presence of map_page, registered
- boot_wr  out  1  SDRAM write strobe
- boot_a  out  ADDR_W  SDRAM byte address; MSB=1 selects the ROM region
- boot_dout  out  8  write data
- load_done  out  1  one-cycle pulse when a download ends
- load_err  out  1  sticky error for the last download
- load_pages  out  PAGE_BITS+1  pages written in the last download
- load_sum  out  16  checksum (see Optional Feature)

Behaviour:
- Reset values: every output 0; FSM in IDLE; presence map all 0.
- FSM states: IDLE, DECODE, LOAD, FINISH.
  - IDLE -> DECODE on a rising edge of ioctl_download with ioctl_index!=0. Index 0 downloads: stay in IDLE, no outputs change.
  - DECODE takes one cycle, then -> LOAD. It sets base and mode:
    - Each character '0'-'9' gives 0-9; 'A'-'F' gives 10-15. base = {hi,lo}, zero-extended or truncated to PAGE_BITS.
    - "ZZ" gives base 0. "Z0" gives base 0 with combo=1.
    - Anything else: bad=1, load_err=1.
    - DECODE also clears load_err (unless bad), load_pages and the checksum.
  - LOAD -> FINISH on a falling edge of ioctl_download.
  - FINISH: load_done=1 for one cycle, then -> IDLE.
- Target page for a byte, with off = ioctl_addr[PAGE_ADDR_W+PAGE_BITS-1:PAGE_ADDR_W]:
  - Normal: tgt = base+off, computed one bit wider than PAGE_BITS.
  - Combo: off==0 gives tgt=0; otherwise tgt = COMBO_PAGE+off-1.
- A byte is accepted when ioctl_wr=1 in LOAD, bad=0, tgt <= 2^PAGE_BITS-1 and the ioctl_addr bits above PAGE_BITS+PAGE_ADDR_W are 0. Otherwise the byte is dropped and load_err is set. There is no wrap-around.
- Accepted bytes, one-cycle registered latency:
  - boot_wr=1 the cycle after ioctl_wr.
  - boot_a = {1'b1, zero padding, tgt[PAGE_BITS-1:0], ioctl_addr[PAGE_ADDR_W-1:0]}; boot_dout = ioctl_dout.
  - boot_wr holds for as many cycles as ioctl_wr was high.
- Presence map:
  - map[tgt] is set on the falling edge of ioctl_wr for an accepted byte.
  - load_pages = max accepted off+1.
  - map_clear clears all bits. If a set coincides with map_clear, the set wins for that page.
  - map_valid = map[map_page], one-cycle latency.
- Reset mid-download: immediate return to IDLE, boot_wr=0, map cleared. The remainder of the download is ignored until a new rising edge of ioctl_download.

Optional Feature:
- Macro: ROM_PAGE_LOADER_CHECKSUM_EN.
- Defined: load_sum is a 16-bit modular sum of accepted bytes, cleared in DECODE and stable from FINISH onwards.
- Undefined: the port remains and load_sum is tied to 0; no adder is synthesised.

Decomposition:
- Package rom_loader_pkg holds:
  - the FSM state enum;
  - ASCII constants for '0', '9', 'A', 'F', 'Z';
  - a function hex_nibble(char) returning {valid, nibble}.
- Sub-module rom_presence_map: bit-array with set, clear and lookup; registered read; async reset.

Test Plan:
- ext "07", index 1, 32 KB file -> boot_a 0x41C000..0x423FFF sequential; map_valid for pages 7 and 8 only; load_pages=2; load_err=0; one load_done pulse.
- ext "Z0", 32 KB -> first 16 KB written to page 0 (0x400000..), second to page 0xFF (0x7FC000..); map bits 0 and 0xFF set.
- ext "FF", 32 KB -> page 0xFF written; second-page bytes dropped (boot_wr never high for them); load_err=1; load_pages=1.
- ext "Q3" -> no boot_wr at all; load_err=1; map unchanged; load_done still pulses.
- Assert reset after 100 bytes of a download, release mid-window -> boot_wr stays 0, map all 0, no load_done until the next download.
- CHECKSUM_EN, 4 bytes 0xFF,0x01,0x80,0x80 -> load_sum=0x0200; with map_clear coinciding with a set on page 3, only bit 3 remains set.
